// File: rtl/rx_module_if.sv
// UART receive bus: serial line and enable toward the receiver, byte/done/error back.
// master drives the line and enable; slave is the receive engine.
interface rx_module_if;
   logic       RX_Pin_In;
   logic       Rx_En_Sig;
   logic       Rx_Done_Sig;
   logic [7:0] Rx_Data;
   logic       Rx_Err_Sig;

   modport master (
      output RX_Pin_In,
      output Rx_En_Sig,
      input  Rx_Done_Sig,
      input  Rx_Data,
      input  Rx_Err_Sig
   );

   modport slave (
      input  RX_Pin_In,
      input  Rx_En_Sig,
      output Rx_Done_Sig,
      output Rx_Data,
      output Rx_Err_Sig
   );
endinterface

// File: rtl/rx_module.sv
// UART receive engine: start, 8 data bits LSB-first, optional even parity, 1 stop.
// Define RX_PARITY_EN to expect a parity bit between data bit 7 and the stop bit.
module rx_module #(
   parameter logic [15:0] BIT_CYCLES  = 16'd5208,
   parameter logic [15:0] HALF_CYCLES = 16'd2604
) (
   input  logic        CLK,
   input  logic        RST,
   rx_module_if.slave  rx_bus
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE
   } state_t;

   state_t      state;
   logic        s1, s2, s3;
   logic        v1, v2, armed;
   logic        fall;
   logic [15:0] cnt;
   logic [3:0]  idx;
   logic [7:0]  shreg;
   logic        done_q;
   logic [7:0]  data_q;
   logic        err_q;
`ifdef RX_PARITY_EN
   logic        par_bit;
`endif

   // v1/v2 mark when s1/s2 hold real line samples rather than reset values;
   // armed requires one genuine high so a line held low through reset is not a start.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s1    <= 1'b1;
         s2    <= 1'b1;
         s3    <= 1'b1;
         v1    <= 1'b0;
         v2    <= 1'b0;
         armed <= 1'b0;
      end else begin
         s1 <= rx_bus.RX_Pin_In;
         s2 <= s1;
         s3 <= s2;
         v1 <= 1'b1;
         v2 <= v1;
         if (v2 && s2)
            armed <= 1'b1;
      end
   end

   assign fall = armed & s3 & ~s2;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         done_q  <= 1'b0;
         data_q  <= '0;
         err_q   <= 1'b0;
`ifdef RX_PARITY_EN
         par_bit <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (fall && rx_bus.Rx_En_Sig)
                  state <= START;
            end

            START: begin
               if (cnt == HALF_CYCLES && s2) begin
                  cnt   <= '0;
                  state <= IDLE;
               end else if (cnt == BIT_CYCLES - 16'd1) begin
                  cnt   <= '0;
                  idx   <= '0;
                  state <= DATA;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            DATA: begin
               if (cnt == HALF_CYCLES)
                  shreg[idx[2:0]] <= s2;
               if (cnt == BIT_CYCLES - 16'd1) begin
                  cnt <= '0;
                  if (idx == 4'd7) begin
`ifdef RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

`ifdef RX_PARITY_EN
            PARITY: begin
               if (cnt == HALF_CYCLES)
                  par_bit <= s2;
               if (cnt == BIT_CYCLES - 16'd1) begin
                  cnt   <= '0;
                  state <= STOP;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end
`endif

            // Outputs are loaded at the stop sample so the pulse spans exactly the DONE cycle.
            STOP: begin
               if (cnt == HALF_CYCLES) begin
                  cnt    <= '0;
                  done_q <= 1'b1;
                  data_q <= shreg;
`ifdef RX_PARITY_EN
                  err_q  <= ~s2 | (^{shreg, par_bit});
`else
                  err_q  <= ~s2;
`endif
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 16'd1;
               end
            end

            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end

            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign rx_bus.Rx_Done_Sig = done_q;
   assign rx_bus.Rx_Data     = data_q;
   assign rx_bus.Rx_Err_Sig  = err_q;

endmodule

// File: tb/tb_rx_module.sv
// Randomised UART frame stimulus with a queued scoreboard of expected byte, error and done time.
module tb_rx_module;

   localparam logic [15:0] BIT_P  = 16'd16;
   localparam logic [15:0] HALF_P = 16'd8;
   localparam int unsigned BIT    = 16;
   localparam int unsigned HALF   = 8;
`ifdef RX_PARITY_EN
   localparam int unsigned NS = 10;
   `define PF(x) , x
`else
   localparam int unsigned NS = 9;
   `define PF(x)
`endif

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   rx_module_if bus();

   rx_module #(.BIT_CYCLES(BIT_P), .HALF_CYCLES(HALF_P)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .rx_bus (bus)
   );

   typedef struct {
      logic [7:0]  data;
      logic        err;
      int unsigned lo;
      int unsigned hi;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   logic        prev_done = 1'b0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      bus.RX_Pin_In = b;
      repeat (BIT) @(posedge CLK);
      #1;
   endtask

   // Called #1 after a rising edge. Expected result follows from the frame contents alone:
   // data = byte sent, error = bad stop bit or odd overall parity.
   task automatic send_frame(input logic [7:0] d, input logic stop_v, input int drop_en_bit,
                             input bit expect_done, input int unsigned gap
`ifdef RX_PARITY_EN
                             , input logic par_flip
`endif
                             );
      exp_t e;
`ifdef RX_PARITY_EN
      logic par_v;
      par_v = (^d) ^ par_flip;
`endif
      if (expect_done) begin
         e.data = d;
`ifdef RX_PARITY_EN
         e.err = (stop_v == 1'b0) || ((^{d, par_v}) == 1'b1);
`else
         e.err = (stop_v == 1'b0);
`endif
         e.lo = cyc + NS * BIT + HALF + 2;
         e.hi = e.lo + 3;
         sb.push_back(e);
      end
      send_bit(1'b0);
      for (int k = 0; k < 8; k++) begin
         if (k == drop_en_bit) bus.Rx_En_Sig = 1'b0;
         send_bit(d[k]);
      end
`ifdef RX_PARITY_EN
      send_bit(par_v);
`endif
      send_bit(stop_v);
      bus.RX_Pin_In = 1'b1;
      repeat (gap) @(posedge CLK);
      #1;
   endtask

   always @(negedge CLK) begin
      exp_t e;
      if (prev_done) begin
         checks++;
         if (bus.Rx_Done_Sig) begin
            errors++;
            $display("FAIL done_width: Rx_Done_Sig=1 on second cycle, required 0");
         end
      end
      if (bus.Rx_Done_Sig && !prev_done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: pulse with Rx_Data=%02h at cycle %0d, no frame pending",
                     bus.Rx_Data, cyc);
         end else begin
            e = sb.pop_front();
            checks += 3;
            if (bus.Rx_Data !== e.data) begin
               errors++;
               $display("FAIL rx_data: got %02h expected %02h", bus.Rx_Data, e.data);
            end
            if (bus.Rx_Err_Sig !== e.err) begin
               errors++;
               $display("FAIL rx_err: got %0b expected %0b (data %02h)", bus.Rx_Err_Sig, e.err, e.data);
            end
            if (cyc < e.lo || cyc > e.hi) begin
               errors++;
               $display("FAIL done_time: cycle %0d expected %0d..%0d", cyc, e.lo, e.hi);
            end
         end
      end
      prev_done = bus.Rx_Done_Sig;
   end

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation exceeded time limit");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0]  d;
      logic        stop_v;
      int unsigned gap;
`ifdef RX_PARITY_EN
      logic        pf;
`endif
      RST = 1'b1;
      bus.RX_Pin_In = 1'b1;
      bus.Rx_En_Sig = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_done", 32'(bus.Rx_Done_Sig), 32'd0);
      chk("reset_data", 32'(bus.Rx_Data), 32'h00);
      chk("reset_err", 32'(bus.Rx_Err_Sig), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      repeat (BIT) @(posedge CLK); #1;

      // Reception disabled: 0xFF must be ignored.
      bus.Rx_En_Sig = 1'b0;
      send_frame(8'hFF, 1'b1, -1, 1'b0, BIT `PF(1'b0));
      bus.Rx_En_Sig = 1'b1;
      @(negedge CLK);
      chk("disabled_data", 32'(bus.Rx_Data), 32'h00);
      chk("disabled_done", 32'(bus.Rx_Done_Sig), 32'd0);
      @(posedge CLK); #1;

      send_frame(8'hA5, 1'b1, -1, 1'b1, BIT `PF(1'b0));

      // Short low glitch is rejected at the start sample.
      bus.RX_Pin_In = 1'b0;
      repeat (3) @(posedge CLK); #1;
      bus.RX_Pin_In = 1'b1;
      repeat (2 * BIT) @(posedge CLK); #1;
      send_frame(8'h3C, 1'b1, -1, 1'b1, BIT `PF(1'b0));

      send_frame(8'h5A, 1'b0, -1, 1'b1, BIT `PF(1'b0));
      send_frame(8'h0F, 1'b1, -1, 1'b1, BIT `PF(1'b0));

      // Enable dropped during bit 3 does not abort the frame.
      send_frame(8'h81, 1'b1, 3, 1'b1, BIT `PF(1'b0));
      bus.Rx_En_Sig = 1'b1;

`ifdef RX_PARITY_EN
      send_frame(8'hA5, 1'b1, -1, 1'b1, BIT, 1'b0);
      send_frame(8'hA5, 1'b1, -1, 1'b1, BIT, 1'b1);
`endif

      // Reset pulse during bit 4 of 0x12.
      d = 8'h12;
      send_bit(1'b0);
      for (int k = 0; k < 4; k++) send_bit(d[k]);
      bus.RX_Pin_In = d[4];
      repeat (4) @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      bus.RX_Pin_In = 1'b1;
      @(negedge CLK);
      chk("midreset_done", 32'(bus.Rx_Done_Sig), 32'd0);
      chk("midreset_data", 32'(bus.Rx_Data), 32'h00);
      chk("midreset_err", 32'(bus.Rx_Err_Sig), 32'd0);
      @(posedge CLK); #1;
      repeat (3 * BIT) @(posedge CLK); #1;

      send_frame(8'h12, 1'b1, -1, 1'b1, 0 `PF(1'b0));
      send_frame(8'h34, 1'b1, -1, 1'b1, BIT `PF(1'b0));

      for (int i = 0; i < 20; i++) begin
         d      = 8'($urandom);
         stop_v = ($urandom_range(0, 4) != 0);
         gap    = stop_v ? $urandom_range(0, BIT) : BIT + $urandom_range(0, BIT);
`ifdef RX_PARITY_EN
         pf     = ($urandom_range(0, 4) == 0);
`endif
         send_frame(d, stop_v, -1, 1'b1, gap `PF(pf));
      end

      repeat (4 * BIT) @(posedge CLK); #1;
      chk("sb_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rx_module.md
# rx_module

UART receive engine: recovers 8-bit frames (start, 8 data bits LSB-first, optional parity, 1 stop) from the asynchronous serial line and presents each byte with a one-cycle done pulse. It pairs with the existing transmit path at the same baud rate; a downstream control module gates reception with an enable signal and consumes `Rx_Data` on `Rx_Done_Sig`. Default line rate is 9600 bps at a 50 MHz clock.

## Interface
- `BIT_CYCLES`, default 16'd5208: clock cycles per bit (50 MHz / 9600); legal range 4..65535.
- `HALF_CYCLES`, default 16'd2604: sample offset within a bit; must equal `BIT_CYCLES/2`.
- `CLK`  in  1  system clock; everything is synchronous to its rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `RX_Pin_In`  in  1  asynchronous serial line; idles high.
- `Rx_En_Sig`  in  1  reception enable; gates start-bit detection only.
- `Rx_Done_Sig`  out  1  one-cycle pulse when a frame completes.
- `Rx_Data`  out  8  last received byte; valid from the `Rx_Done_Sig` cycle until the next one.
- `Rx_Err_Sig`  out  1  error flag for the frame just completed; valid on `Rx_Done_Sig` and held until the next one.

## Operation
- Input conditioning: `RX_Pin_In` passes through two flip-flops (s1, s2) and then a third register (s3). A falling edge is `s3 & ~s2`. All three registers reset to 1.
- 16-bit bit-period counter `cnt`. A 4-bit bit index `idx`.
- States:
  - IDLE: `cnt`=0. On a falling edge with `Rx_En_Sig`=1, go to START and set `cnt`=0.
  - START: `cnt` increments. At `cnt==HALF_CYCLES`, sample s2. If the sample is 1 (glitch), return to IDLE without a done pulse. At `cnt==BIT_CYCLES-1`, set `cnt`=0 and `idx`=0, and go to DATA.
  - DATA: at `cnt==HALF_CYCLES`, shift s2 into shift-register bit `idx` (LSB first). At `cnt==BIT_CYCLES-1`, set `cnt`=0. If `idx==7`, go to PARITY (macro defined) or STOP; otherwise increment `idx`.
  - PARITY (macro only): at `cnt==HALF_CYCLES`, sample the parity bit. At `cnt==BIT_CYCLES-1`, go to STOP.
  - STOP: at `cnt==HALF_CYCLES`, sample s2 and go to DONE. The state machine does not wait for the end of the stop bit.
  - DONE: for one cycle, `Rx_Done_Sig`=1, `Rx_Data`=shift register, and `Rx_Err_Sig`=(stop sample==0) OR parity mismatch. Then go to IDLE.
- `Rx_En_Sig` deasserted mid-frame does not abort the frame; the frame completes normally.
- A framing error still updates `Rx_Data` with the bits that were received.
- Reset mid-frame: the state machine goes to IDLE, and `cnt`, `idx`, the shift register, and all outputs clear on the next edge. Reception resumes only on a fresh falling edge.
- While RX is held low after reset, no start is detected until the line goes high and then falls again.

## Timing
- Reset values: `Rx_Done_Sig`=0, `Rx_Data`=8'h00, `Rx_Err_Sig`=0, state=IDLE, s1/s2/s3=1.
- Let E be the first `CLK` edge at which s2 shows the line low. The falling edge is detected and START is entered at E.
- The start sample occurs at E+`HALF_CYCLES`.
- Data bit k (0..7) is sampled at E+(k+1)·`BIT_CYCLES`+`HALF_CYCLES`.
- The stop bit is sampled at E+9·`BIT_CYCLES`+`HALF_CYCLES`, or E+10·`BIT_CYCLES`+`HALF_CYCLES` with parity.
- `Rx_Done_Sig` is high for exactly one cycle, the cycle after the stop sample.
- Back-to-back frames are supported: IDLE is re-entered about half a bit before the next start edge.
- `Rx_Done_Sig` is never asserted twice per frame and is never asserted without a valid start.

## Configuration
- `RX_PARITY_EN`:
  - Defined: a parity bit is expected between bit 7 and stop. Even parity is required, i.e. XOR of the 8 data bits and the parity bit must be 0. A mismatch sets `Rx_Err_Sig`. Frame length is 11 bits.
  - Undefined: no PARITY state, 10-bit frames, and `Rx_Err_Sig` reflects stop-bit errors only.

## Test plan
- Enabled; send 0xA5 at 9600 bps → one `Rx_Done_Sig` pulse with `Rx_Data`=8'hA5 and `Rx_Err_Sig`=0. Done occurs 9·5208+2604+1 cycles after E (±1).
- Drive RX low for 100 cycles and then high → no done pulse; state returns to IDLE. A following 0x3C frame is received correctly.
- Send 0x5A with stop bit=0 → done with `Rx_Data`=8'h5A and `Rx_Err_Sig`=1. The next good frame 0x0F clears `Rx_Err_Sig` to 0.
- `Rx_En_Sig`=0 while 0xFF is sent → no done pulse and `Rx_Data` stays 8'h00. Deasserting `Rx_En_Sig` during bit 3 of a 0x81 frame → 0x81 is still received.
- Assert `RST` for one cycle during bit 4 of a frame → all outputs are 0 and the state is IDLE. Back-to-back 0x12 and 0x34 afterwards → two done pulses with the correct data.
- With `RX_PARITY_EN` defined: 0xA5 with parity 0 → `Rx_Err_Sig`=0. 0xA5 with parity 1 → `Rx_Err_Sig`=1.
